// File: rtl/decode_pkg.sv
// Shared types and constants for the rv5stage decode stage: pipeline bundles, ALU ops, opcodes.
package decode_pkg;

    localparam logic [31:0] NopInst = 32'h0000_0013;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpFence  = 7'b0001111;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
    } AluOp;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } FetchInfo;

    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;

    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7_5;
        AluOp        alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src_imm;
        logic        valid;
        logic        illegal;
    } DecodeInfo;

    // funct7[5] only selects SUB for register-register ops; it selects SRA for both forms.
    function automatic AluOp alu_sel(logic [2:0] funct3, logic funct7_5, logic is_reg);
        unique case (funct3)
            3'b000:  return (is_reg && funct7_5) ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return funct7_5 ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    function automatic AluOp branch_alu(logic [2:0] funct3);
        unique case (funct3[2:1])
            2'b10:   return AluSlt;
            2'b11:   return AluSltu;
            default: return AluSub;
        endcase
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: selects the RV32I immediate format from the opcode and sign-extends it.
module decode_imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (inst[6:0])
            OpLui, OpAuipc: imm = {inst[31:12], 12'b0};
            OpJal:          imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            OpBranch:       imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            OpStore:        imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
            OpJalr, OpLoad, OpImm, OpSystem, OpFence:
                            imm = {{21{inst[31]}}, inst[30:20]};
            default:        imm = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// ID stage: IF/ID register, RV32I decode into DecodeInfo, and load-use hazard detection.
module decode
    import decode_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NopInst
) (
    input  logic       clk,
    input  logic       rst,
    input  FetchInfo   fetch_info,
    input  PipeControl if_id_pipe,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output PipeRequest req,
    output DecodeInfo  info,
    output logic       error
);

    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (if_id_pipe.stall) begin
            pc_q    <= pc_q;
            inst_q  <= inst_q;
            valid_q <= valid_q;
        end else if (if_id_pipe.flush) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= fetch_info.pc;
            inst_q  <= fetch_info.inst;
            valid_q <= 1'b1;
        end
    end

    logic [31:0] imm;

    decode_imm_gen u_imm_gen (
        .inst (inst_q),
        .imm  (imm)
    );

    logic known, illegal, hazard;
    logic rs1_used, rs2_used;
    logic reg_write, mem_read, mem_write, branch, jump, alu_src_imm;
    AluOp alu_op;

    always_comb begin
        known       = 1'b1;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = AluAdd;
        unique case (inst_q[6:0])
            OpLui:    begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = AluPassB; end
            OpAuipc:  begin reg_write = 1'b1; alu_src_imm = 1'b1; end
            OpJal:    begin reg_write = 1'b1; jump = 1'b1; end
            OpJalr:   begin reg_write = 1'b1; jump = 1'b1; alu_src_imm = 1'b1; rs1_used = 1'b1; end
            OpBranch: begin
                branch   = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                alu_op   = branch_alu(inst_q[14:12]);
            end
            OpLoad:   begin
                reg_write   = 1'b1;
                mem_read    = 1'b1;
                alu_src_imm = 1'b1;
                rs1_used    = 1'b1;
            end
            OpStore:  begin mem_write = 1'b1; alu_src_imm = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
            OpImm:    begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                rs1_used    = 1'b1;
                alu_op      = alu_sel(inst_q[14:12], inst_q[30], 1'b0);
            end
            OpReg:    begin
                reg_write = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                alu_op    = alu_sel(inst_q[14:12], inst_q[30], 1'b1);
            end
            OpSystem, OpFence: ;
            default:  known = 1'b0;
        endcase

        illegal = valid_q && (!known || inst_q[1:0] != 2'b11);
        // An illegal instruction must not write state or create a hazard.
        if (illegal) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
            rs1_used  = 1'b0;
            rs2_used  = 1'b0;
        end

        hazard = valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                 ((rs1_used && inst_q[19:15] == ex_rd) || (rs2_used && inst_q[24:20] == ex_rd));
    end

    always_comb begin
        info.pc          = pc_q;
        info.imm         = imm;
        info.rd          = reg_write ? inst_q[11:7]  : 5'd0;
        info.rs1         = rs1_used  ? inst_q[19:15] : 5'd0;
        info.rs2         = rs2_used  ? inst_q[24:20] : 5'd0;
        info.funct3      = inst_q[14:12];
        info.funct7_5    = inst_q[30];
        info.alu_op      = alu_op;
        info.reg_write   = reg_write;
        info.mem_read    = mem_read;
        info.mem_write   = mem_write;
        info.branch      = branch;
        info.jump        = jump;
        info.alu_src_imm = alu_src_imm;
        info.valid       = valid_q;
        info.illegal     = illegal;

        req.stall_req = hazard;
        req.flush_req = hazard ? 4'b0010 : 4'b0000;
        error         = illegal;
    end

endmodule
